// File: rtl/booth_datapath.sv
// booth_datapath: radix-2 Booth signed-multiplier datapath driven by an external
// controller FSM. Holds the operand registers, runs one add/subtract-and-shift
// step per enabled cycle, flags completion on count and captures the product
// on load_P.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   a_in  [WIDTH]       multiplicand (two's complement)
//   b_in  [WIDTH]       multiplier   (two's complement)
//   enable_A            load multiplicand (load phase only)
//   enable_B            load multiplier, clear step state (load phase only)
//   enable_PP           run one Booth step per cycle
//   load_P              capture product when count is high
//   count               registered: all WIDTH steps complete
//   product [2*WIDTH]   registered signed product
//   product_valid       registered: product belongs to the current operand pair
module booth_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 enable_A,
  input  logic                 enable_B,
  input  logic                 enable_PP,
  input  logic                 load_P,
  output logic                 count,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_valid
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned SW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0] STEP_DONE = SW'(WIDTH);

  logic [AW-1:0]    a_q, a_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [SW-1:0]    step_q, step_d;
  logic             count_q, count_d;
  logic [PW-1:0]    product_q, product_d;
  logic             valid_q, valid_d;

  logic [AW-1:0]    sum;
  logic             step_en;
  logic             capture;

  // A step runs only while enabled, not done, and not already past the last step
  // (step parks at WIDTH after capture so a lingering enable_PP cannot rerun).
  assign step_en = enable_PP && !count_q && (step_q != STEP_DONE);
  assign capture = load_P && count_q;

  // Booth recode of {Q[0], q_m1}; WIDTH+1 bits means no overflow for any operand.
  always_comb begin
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + a_q;
      2'b10:   sum = acc_q - a_q;
      default: sum = acc_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    a_d       = a_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    step_d    = step_q;
    count_d   = count_q;
    product_d = product_q;
    valid_d   = valid_q;

    if (!enable_PP && enable_A) begin
      a_d = {a_in[WIDTH-1], a_in};
    end

    if (step_en) begin
      // Arithmetic shift right of {ACC, Q, q_m1} after the add/subtract
      acc_d  = {sum[AW-1], sum[AW-1:1]};
      q_d    = {sum[0], q_q[WIDTH-1:1]};
      qm1_d  = q_q[0];
      step_d = step_q + SW'(1);
      if (step_q == STEP_LAST) begin
        count_d = 1'b1;
      end
    end

    if (capture) begin
      product_d = {acc_q[WIDTH-1:0], q_q};
      valid_d   = 1'b1;
      count_d   = 1'b0;
    end

    // A new multiplier load restarts the operation; product itself is kept.
    if (!enable_PP && enable_B) begin
      q_d     = b_in;
      acc_d   = '0;
      qm1_d   = 1'b0;
      step_d  = '0;
      count_d = 1'b0;
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      step_q    <= '0;
      count_q   <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      a_q       <= a_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      step_q    <= step_d;
      count_q   <= count_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign count         = count_q;
  assign product       = product_q;
  assign product_valid = valid_q;

endmodule

// File: tb/tb_booth_datapath.sv
module tb_booth_datapath;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   a_in, b_in;
  logic           enable_A, enable_B, enable_PP, load_P;
  logic           count;
  logic [2*W-1:0] product;
  logic           product_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs[9];

  booth_datapath #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_in         (a_in),
    .b_in         (b_in),
    .enable_A     (enable_A),
    .enable_B     (enable_B),
    .enable_PP    (enable_PP),
    .load_P       (load_P),
    .count        (count),
    .product      (product),
    .product_valid(product_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in = a; b_in = b; enable_A = 1'b1; enable_B = 1'b1;
    tick();
    enable_A = 1'b0; enable_B = 1'b0;
  endtask

  // Hold enable_PP until count rises (bounded); returns edges taken.
  task automatic run_steps(output int edges);
    edges = 0;
    enable_PP = 1'b1;
    while (!count && edges < 40) begin
      tick();
      edges++;
    end
    enable_PP = 1'b0;
  endtask

  // Controller: one edge to enter its load_P state, then load_P for one edge.
  task automatic capture_seq();
    tick();
    load_P = 1'b1;
    tick();
    load_P = 1'b0;
  endtask

  initial begin
    int edges;
    logic [2*W-1:0] saved;

    vecs[0] = '{8'h03, 8'h05, 16'h000F};
    vecs[1] = '{8'hF9, 8'h06, 16'hFFD6};
    vecs[2] = '{8'h80, 8'h80, 16'h4000};
    vecs[3] = '{8'h7F, 8'h80, 16'hC080};
    vecs[4] = '{8'h02, 8'hFD, 16'hFFFA};
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[6] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[7] = '{8'h00, 8'h55, 16'h0000};
    vecs[8] = '{8'h01, 8'h80, 16'hFF80};

    reset = 1'b1; a_in = '0; b_in = '0;
    enable_A = 1'b0; enable_B = 1'b0; enable_PP = 1'b0; load_P = 1'b0;
    tick(); tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_valid", 32'(product_valid), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven full controller sequences
    for (int i = 0; i < 9; i++) begin
      load_ops(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_valid_cleared", i), 32'(product_valid), 32'd0);
      run_steps(edges);
      check($sformatf("v%0d_count_latency", i), 32'(edges), 32'd8);
      capture_seq();
      check($sformatf("v%0d_product", i), 32'(product), 32'(vecs[i].prod));
      check($sformatf("v%0d_valid", i), 32'(product_valid), 32'd1);
      check($sformatf("v%0d_count_dropped", i), 32'(count), 32'd0);
    end

    // load_P with count low, and lingering enable_PP after capture: no effect
    saved = product;
    enable_PP = 1'b1;
    repeat (3) tick();
    check("no_rerun_count", 32'(count), 32'd0);
    enable_PP = 1'b0;
    load_P = 1'b1;
    tick();
    load_P = 1'b0;
    check("ignored_loadp_product", 32'(product), 32'(saved));
    check("ignored_loadp_valid", 32'(product_valid), 32'd1);

    // enable_B clears valid but keeps product
    load_ops(8'h03, 8'h05);
    check("reload_keeps_product", 32'(product), 32'(saved));
    check("reload_clears_valid", 32'(product_valid), 32'd0);

    // Stall after step 4; enable_A/load_P pulses during steps must be ignored
    enable_PP = 1'b1;
    edges = 0;
    tick(); edges++;
    a_in = 8'h55; enable_A = 1'b1; enable_B = 1'b1; b_in = 8'h11; load_P = 1'b1;
    tick(); edges++;
    enable_A = 1'b0; enable_B = 1'b0; load_P = 1'b0;
    repeat (2) begin tick(); edges++; end
    enable_PP = 1'b0;
    repeat (3) begin tick(); edges++; end
    check("stall_count_low", 32'(count), 32'd0);
    check("stall_valid_low", 32'(product_valid), 32'd0);
    enable_PP = 1'b1;
    while (!count && edges < 60) begin
      tick();
      edges++;
    end
    enable_PP = 1'b0;
    check("stall_latency", 32'(edges), 32'd11);
    capture_seq();
    check("stall_product", 32'(product), 32'h000F);
    check("stall_valid", 32'(product_valid), 32'd1);

    // count holds with enable_PP high while waiting for load_P
    load_ops(8'h02, 8'h07);
    run_steps(edges);
    enable_PP = 1'b1;
    repeat (2) tick();
    check("done_hold_count", 32'(count), 32'd1);
    enable_PP = 1'b0;
    capture_seq();
    check("done_hold_product", 32'(product), 32'h000E);

    // Asynchronous reset mid-step
    load_ops(8'h03, 8'h05);
    enable_PP = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("async_reset_count", 32'(count), 32'd0);
    check("async_reset_product", 32'(product), 32'd0);
    check("async_reset_valid", 32'(product_valid), 32'd0);
    load_P = 1'b1;
    tick(); tick();
    check("reset_no_capture", 32'(product), 32'd0);
    load_P = 1'b0; enable_PP = 1'b0;
    reset = 1'b0;
    tick();

    load_ops(8'h02, 8'hFD);
    run_steps(edges);
    check("after_reset_latency", 32'(edges), 32'd8);
    capture_seq();
    check("after_reset_product", 32'(product), 32'hFFFA);
    check("after_reset_valid", 32'(product_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
